// File: rtl/sequence_receiver.sv
// Serial-to-parallel receiver: assembles DATA_WIDTH bits from ds into dout with a dv strobe.
// Optional match detector enabled by defining SEQ_RX_MATCH_EN.
module sequence_receiver #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] MATCH_WORD = 8'h0F
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  sync,
    input  logic                  ds,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dv,
    output logic                  busy,
    output logic                  resync,
    output logic                  match
);

    localparam int             CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dv_q, dv_d;
    logic                    resync_q, resync_d;
    logic                    match_q, match_d;
    logic [DATA_WIDTH-1:0]   base;
    logic [DATA_WIDTH-1:0]   word;

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                       input logic b);
        if (MSB_FIRST)
            return {cur[DATA_WIDTH-2:0], b};
        else
            return {b, cur[DATA_WIDTH-1:1]};
    endfunction

    // A fresh frame (cnt==0 or a resync) starts from a cleared register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        resync_d = 1'b0;
        match_d  = 1'b0;
        base     = (cnt_q == '0) ? '0 : shreg_q;
        word     = shift_in(base, ds);

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (sync) begin
                        shreg_d = shift_in('0, ds);
                        cnt_d   = CNT_ONE;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (sync && (cnt_q != '0)) begin
                        shreg_d  = shift_in('0, ds);
                        cnt_d    = CNT_ONE;
                        resync_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        shreg_d = word;
                        dout_d  = word;
                        dv_d    = 1'b1;
                        cnt_d   = '0;
`ifdef SEQ_RX_MATCH_EN
                        match_d = (word == MATCH_WORD);
`endif
                    end else begin
                        shreg_d = word;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifndef SEQ_RX_MATCH_EN
    logic unused_match_word;
    assign unused_match_word = ^MATCH_WORD;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            resync_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            resync_q <= resync_d;
            match_q  <= match_d;
        end
    end

    assign dout   = dout_q;
    assign dv     = dv_q;
    assign resync = resync_q;
    assign match  = match_q;
    assign busy   = (state_q == S_SHIFT) && (cnt_q != '0);

endmodule

// File: tb/tb_sequence_receiver.sv
// Self-checking bench for sequence_receiver: directed table, hand sequences, random vs. queue model.
module tb_sequence_receiver;

    localparam int          DW  = 8;
    localparam bit          MSB = 1'b1;
    localparam logic [7:0]  MW  = 8'h0F;
`ifdef SEQ_RX_MATCH_EN
    localparam bit MATCH_ON = 1'b1;
`else
    localparam bit MATCH_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0, sync = 1'b0, ds = 1'b0;
    logic [DW-1:0] dout;
    logic          dv, busy, resync, match;

    sequence_receiver #(.DATA_WIDTH(DW), .MSB_FIRST(MSB), .MATCH_WORD(MW)) dut (
        .clk(clk), .clr(clr), .en(en), .sync(sync), .ds(ds),
        .dout(dout), .dv(dv), .busy(busy), .resync(resync), .match(match)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dv_cycles[$];

    // Reference model: a frame is a list of received bits.
    bit         m_in_frame;
    bit         m_q[$];
    logic [7:0] m_dout;
    bit         m_dv, m_resync, m_match;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_q.delete();
        m_dout = '0;
        m_dv = 1'b0; m_resync = 1'b0; m_match = 1'b0;
    endfunction

    function automatic void model_update(input bit e, input bit s, input bit d);
        logic [7:0] w;
        m_dv = 1'b0; m_resync = 1'b0; m_match = 1'b0;
        if (!e) return;
        if (!m_in_frame) begin
            if (s) begin
                m_in_frame = 1'b1;
                m_q.delete();
                m_q.push_back(d);
            end
        end else if (s && m_q.size() != 0) begin
            m_q.delete();
            m_q.push_back(d);
            m_resync = 1'b1;
        end else begin
            m_q.push_back(d);
            if (m_q.size() == DW) begin
                w = '0;
                for (int i = 0; i < DW; i++) begin
                    if (MSB) w[DW-1-i] = m_q[i];
                    else     w[i]      = m_q[i];
                end
                m_dout  = w;
                m_dv    = 1'b1;
                m_match = MATCH_ON && (w == MW);
                m_q.delete();
            end
        end
    endfunction

    function automatic void check_model();
        check("m_dout",   32'(dout),   32'(m_dout));
        check("m_dv",     32'(dv),     32'(m_dv));
        check("m_busy",   32'(busy),   32'(m_in_frame && m_q.size() != 0));
        check("m_resync", 32'(resync), 32'(m_resync));
        check("m_match",  32'(match),  32'(m_match));
    endfunction

    task automatic step(input logic e, input logic s, input logic d);
        en = e; sync = s; ds = d;
        @(posedge clk);
        cyc++;
        model_update(e, s, d);
        #1;
        check_model();
        if (dv === 1'b1) dv_cycles.push_back(cyc);
    endtask

    // Assert clr for 4ns mid-cycle; outputs must clear immediately.
    task automatic pulse_clr(input string name);
        @(negedge clk);
        clr = 1'b1;
        #1;
        model_reset();
        check({name, "_dout"},   32'(dout),   32'h0);
        check({name, "_dv"},     32'(dv),     32'h0);
        check({name, "_busy"},   32'(busy),   32'h0);
        check({name, "_resync"}, 32'(resync), 32'h0);
        check({name, "_match"},  32'(match),  32'h0);
        #3;
        clr = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit sync_first);
        for (int i = 0; i < DW; i++)
            step(1'b1, sync_first && (i == 0), MSB ? w[DW-1-i] : w[i]);
    endtask

    typedef struct {
        logic       en, sync, ds;
        logic       dv;
        logic [7:0] dout;
        logic       busy, resync;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic e, input logic s, input logic d, input logic v,
                                input logic [7:0] o, input logic b, input logic r);
        vec_t t;
        t.en = e; t.sync = s; t.ds = d; t.dv = v; t.dout = o; t.busy = b; t.resync = r;
        tbl.push_back(t);
    endfunction

    initial begin
        int start;
        model_reset();

        // Frame 0x0E, MSB first, sync on first bit
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h0E, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h0E, 1'b0, 1'b0);
        // Resync at the third bit; the following 8 bits form 0xAA
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h0E, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0);

        // Reset, then ds toggling without sync must never produce a word
        pulse_clr("reset");
        dv_cycles.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'(i % 2));
        check("idle_dv_count", 32'(dv_cycles.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].sync, tbl[i].ds);
            check($sformatf("tbl%0d_dv", i),     32'(dv),     32'(tbl[i].dv));
            check($sformatf("tbl%0d_dout", i),   32'(dout),   32'(tbl[i].dout));
            check($sformatf("tbl%0d_busy", i),   32'(busy),   32'(tbl[i].busy));
            check($sformatf("tbl%0d_resync", i), 32'(resync), 32'(tbl[i].resync));
        end

        // Back-to-back words with a single sync
        dv_cycles.delete();
        send_word(8'h0E, 1'b1);
        check("b2b_dout0", 32'(dout), 32'h0E);
        send_word(8'h0F, 1'b0);
        check("b2b_dout1", 32'(dout), 32'h0F);
        check("b2b_dv_count", 32'(dv_cycles.size()), 32'd2);
        if (dv_cycles.size() == 2)
            check("b2b_dv_period", 32'(dv_cycles[1] - dv_cycles[0]), 32'd8);
        step(1'b0, 1'b0, 1'b0);

        // 0xA5 with three idle cycles after bit 4
        dv_cycles.delete();
        start = cyc + 1;
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'(8'hA5 >> (7 - i)));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 4; i < 8; i++) step(1'b1, 1'b0, 1'(8'hA5 >> (7 - i)));
        check("gap_dout", 32'(dout), 32'hA5);
        check("gap_dv_count", 32'(dv_cycles.size()), 32'd1);
        if (dv_cycles.size() == 1)
            check("gap_dv_latency", 32'(dv_cycles[0] - start), 32'd10);

        // Reset mid-frame, then a fresh 0x3C frame
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
        pulse_clr("midclr");
        send_word(8'h3C, 1'b0);
        check("midclr_nosync_dout", 32'(dout), 32'h00);
        send_word(8'h3C, 1'b1);
        check("midclr_dout", 32'(dout), 32'h3C);
        check("midclr_dv", 32'(dv), 32'd1);

        // Match detector
        send_word(8'h0F, 1'b1);
        check("match_0F", 32'(match), 32'(MATCH_ON));
        send_word(8'h0E, 1'b1);
        check("match_0E", 32'(match), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) pulse_clr("rnd_clr");
            if (i % 200 < 100)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom));
            else
                step($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
